// File: rtl/tcb_pkg.sv
// Shared TCB definitions: bus endianness mode and the endianness resolution
// rule used by both the RTL and the verification components.
package tcb_pkg;

  // Bus endianness mode; bit 0 of LITTLE/BIG is the forced byte order.
  typedef enum logic [1:0] {
    TCB_NDN_DEFAULT = 2'b00,
    TCB_NDN_BI_NDN  = 2'b01,
    TCB_NDN_LITTLE  = 2'b10,
    TCB_NDN_BIG     = 2'b11
  } tcb_ndn_t;

  typedef struct packed {
    logic ndn;  // resolved transfer endianness
    logic err;  // requested endianness conflicts with the bus mode
  } tcb_ndn_res_t;

  // An unknown (X/Z) request never counts as a mismatch and falls back to
  // the native order where the mode lets the manager choose.
  function automatic tcb_ndn_res_t tcb_ndn_resolve(
    input tcb_ndn_t mode,
    input logic     ord,
    input logic     ndn
  );
    tcb_ndn_res_t res;
    logic         known;
    known   = !$isunknown(ndn);
    res.ndn = ord;
    res.err = 1'b0;
    case (mode)
      TCB_NDN_DEFAULT: res.err = known && (ndn != ord);
      TCB_NDN_BI_NDN:  if (known) res.ndn = ndn;
      default: begin
        res.ndn = mode[0];
        res.err = known && (ndn != mode[0]);
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/tcb_arb_rr_pri.sv
// Rotating-priority encoder: picks the first set bit of vec_i starting at
// ptr_i and wrapping from N-1 back to 0. Reusable by other arbiters.
module tcb_arb_rr_pri #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] pos;
  logic        found;

  // Walk the requests in priority order and latch onto the first hit.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    pos      = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && vec_i[pos[IW-1:0]]) begin
        found                  = 1'b1;
        idx_o                  = pos[IW-1:0];
        onehot_o[pos[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcb_arb_rr.sv
// Round-robin arbiter sharing one TCB subordinate between MGR_N managers.
// Resolves transfer endianness, flags mismatches and routes each response
// back to the manager that issued the request.
// Optional macro TCB_ARB_RR_LOCK_EN adds mgr_lck for atomic sequences.
module tcb_arb_rr
  import tcb_pkg::*;
#(
  parameter int unsigned MGR_N = 2,
  parameter int unsigned DLY   = 1,
  parameter tcb_ndn_t    NDN   = TCB_NDN_BI_NDN,
  parameter logic        ORD   = 1'b0,
  parameter int unsigned REQ_W = 72,
  parameter int unsigned RSP_W = 33
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [MGR_N-1:0]       mgr_vld,
  input  logic [MGR_N-1:0]       mgr_ndn,
  input  logic [MGR_N*REQ_W-1:0] mgr_req,
`ifdef TCB_ARB_RR_LOCK_EN
  input  logic [MGR_N-1:0]       mgr_lck,
`endif
  output logic [MGR_N-1:0]       mgr_rdy,
  output logic [RSP_W-1:0]       mgr_rsp,
  output logic [MGR_N-1:0]       mgr_rsp_vld,
  output logic                   sub_vld,
  output logic                   sub_ndn,
  output logic [REQ_W-1:0]       sub_req,
  input  logic                   sub_rdy,
  input  logic [RSP_W-1:0]       sub_rsp,
  output logic                   err_ndn
);

  localparam int unsigned IW = (MGR_N > 1) ? $clog2(MGR_N) : 1;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d;
  logic             err_q;
  logic [IW-1:0]    pri_idx, gnt_idx;
  logic [MGR_N-1:0] pri_oh, gnt_oh;
  logic             hold, xfer, atomic;
  tcb_ndn_res_t     ndn_res;

  tcb_arb_rr_pri #(
    .N  (MGR_N),
    .IW (IW)
  ) u_pri (
    .vec_i    (mgr_vld),
    .ptr_i    (ptr_q),
    .onehot_o (pri_oh),
    .idx_o    (pri_idx)
  );

  // The held grant only applies while its owner still requests, so a
  // withdrawn lock never drives another manager's payload downstream.
  assign hold    = lock_q & mgr_vld[lock_idx_q];
  assign gnt_idx = hold ? lock_idx_q : pri_idx;
  assign gnt_oh  = hold ? (MGR_N'(1) << lock_idx_q) : pri_oh;

  assign sub_vld = |mgr_vld;
  assign xfer    = sub_vld & sub_rdy;
  assign mgr_rdy = {MGR_N{xfer}} & gnt_oh;
  assign mgr_rsp = sub_rsp;

`ifdef TCB_ARB_RR_LOCK_EN
  assign atomic = mgr_lck[gnt_idx];
`else
  assign atomic = 1'b0;
`endif

  // Forward the granted manager's payload to the subordinate.
  always_comb begin
    sub_req = '0;
    for (int i = 0; i < MGR_N; i++) begin
      if (gnt_idx == IW'(i)) sub_req = mgr_req[i*REQ_W +: REQ_W];
    end
  end

  assign ndn_res = tcb_ndn_resolve(NDN, ORD, mgr_ndn[gnt_idx]);
  assign sub_ndn = ndn_res.ndn;
  assign err_ndn = err_q;

  // Next grant lock and priority pointer: stalls and atomic transfers hold
  // the grant, every other completed transfer rotates priority past it.
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (sub_vld && !sub_rdy) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end else if (xfer) begin
      lock_d     = atomic;
      lock_idx_d = gnt_idx;
      if (!atomic) ptr_d = (gnt_idx == IW'(MGR_N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Arbitration state and the one-cycle endianness error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= xfer & ndn_res.err;
    end
  end

  if (DLY == 0) begin : g_nodly
    assign mgr_rsp_vld = {MGR_N{xfer}} & gnt_oh;
  end else begin : g_dly
    logic [DLY-1:0] own_vld_q;
    logic [IW-1:0]  own_idx_q [DLY];

    // Owner pipeline: tracks which manager each in-flight response belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        own_vld_q <= '0;
        for (int i = 0; i < DLY; i++) own_idx_q[i] <= '0;
      end else begin
        own_vld_q[0] <= xfer;
        own_idx_q[0] <= gnt_idx;
        for (int i = 1; i < DLY; i++) begin
          own_vld_q[i] <= own_vld_q[i-1];
          own_idx_q[i] <= own_idx_q[i-1];
        end
      end
    end

    assign mgr_rsp_vld = own_vld_q[DLY-1] ? (MGR_N'(1) << own_idx_q[DLY-1]) : '0;
  end

endmodule

// File: tb/tb_tcb_arb_rr.sv
// Bench for tcb_arb_rr: three configurations share one stimulus stream and
// are compared against a transaction-level reference model.
module tb_tcb_arb_rr;
  import tcb_pkg::*;

  localparam int N     = 3;
  localparam int REQ_W = 72;
  localparam int RSP_W = 33;
  localparam int NDUT  = 3;

  function automatic int dly_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic tcb_ndn_t mode_of(input int k);
    case (k)
      0:       return TCB_NDN_LITTLE;
      1:       return TCB_NDN_BI_NDN;
      default: return TCB_NDN_DEFAULT;
    endcase
  endfunction

  function automatic logic ord_of(input int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [N-1:0]         mgr_vld, mgr_ndn;
  logic [N*REQ_W-1:0]   mgr_req;
  logic                 sub_rdy;
  logic [RSP_W-1:0]     sub_rsp;
`ifdef TCB_ARB_RR_LOCK_EN
  logic [N-1:0]         mgr_lck;
`endif

  logic [N-1:0]         rdy  [NDUT];
  logic [RSP_W-1:0]     rsp  [NDUT];
  logic [N-1:0]         rvld [NDUT];
  logic                 svld [NDUT];
  logic                 sndn [NDUT];
  logic [REQ_W-1:0]     sreq [NDUT];
  logic                 err  [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    tcb_arb_rr #(
      .MGR_N (N),
      .DLY   (dly_of(k)),
      .NDN   (mode_of(k)),
      .ORD   (ord_of(k)),
      .REQ_W (REQ_W),
      .RSP_W (RSP_W)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mgr_vld     (mgr_vld),
      .mgr_ndn     (mgr_ndn),
      .mgr_req     (mgr_req),
`ifdef TCB_ARB_RR_LOCK_EN
      .mgr_lck     (mgr_lck),
`endif
      .mgr_rdy     (rdy[k]),
      .mgr_rsp     (rsp[k]),
      .mgr_rsp_vld (rvld[k]),
      .sub_vld     (svld[k]),
      .sub_ndn     (sndn[k]),
      .sub_req     (sreq[k]),
      .sub_rdy     (sub_rdy),
      .sub_rsp     (sub_rsp),
      .err_ndn     (err[k])
    );
  end

  int checks   = 0;
  int failures = 0;

  // reference model state
  int ptr, lock_idx, g, last_g;
  bit locked, any, xfer, last_xfer;
  bit hv [4];
  int hi [4];
  bit err_exp [NDUT];
  bit mis     [NDUT];

  function automatic void chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic int model_grant();
    if (locked && mgr_vld[lock_idx]) return lock_idx;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (mgr_vld[j]) return j;
    end
    return 0;
  endfunction

  task automatic exp_ndn(input int k, output logic e_ndn, output bit e_mis);
    logic     n;
    bit       known;
    tcb_ndn_t mode;
    logic     target;
    n     = mgr_ndn[g];
    known = !$isunknown(n);
    mode  = mode_of(k);
    if (mode == TCB_NDN_BI_NDN) begin
      e_ndn = known ? n : ord_of(k);
      e_mis = 1'b0;
    end else begin
      target = (mode == TCB_NDN_DEFAULT) ? ord_of(k) : mode[0];
      e_ndn  = target;
      e_mis  = known && (n != target);
    end
  endtask

  task automatic model_reset();
    ptr = 0; locked = 0; lock_idx = 0; last_xfer = 0; last_g = 0;
    for (int i = 0; i < 4; i++) begin hv[i] = 0; hi[i] = 0; end
    for (int k = 0; k < NDUT; k++) begin err_exp[k] = 0; mis[k] = 0; end
  endtask

  // Check one cycle (inputs already applied at the negedge), then advance.
  task automatic run_cycle();
    logic [N-1:0] exp_rvld;
    logic         e_ndn;
    bit           e_mis;
    bit           lk;
    int           d;
    #1;
    any  = |mgr_vld;
    g    = model_grant();
    xfer = any && sub_rdy;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("sub_vld%0d", k), 128'(svld[k]), 128'(any));
      chk($sformatf("mgr_rsp%0d", k), 128'(rsp[k]), 128'(sub_rsp));
      chk($sformatf("err_ndn%0d", k), 128'(err[k]), 128'(err_exp[k]));
      if (any) begin
        chk($sformatf("sub_req%0d", k), 128'(sreq[k]), 128'(mgr_req[g*REQ_W +: REQ_W]));
        chk($sformatf("mgr_rdy%0d", k), 128'(rdy[k]), 128'(sub_rdy ? (N'(1) << g) : N'(0)));
        exp_ndn(k, e_ndn, e_mis);
        chk($sformatf("sub_ndn%0d", k), 128'(sndn[k]), 128'(e_ndn));
        mis[k] = e_mis;
      end else begin
        chk($sformatf("mgr_rdy_idle%0d", k), 128'(rdy[k]), 128'(0));
        mis[k] = 0;
      end
      d = dly_of(k);
      if (d == 0) exp_rvld = xfer ? (N'(1) << g) : '0;
      else        exp_rvld = hv[d-1] ? (N'(1) << hi[d-1]) : '0;
      chk($sformatf("rsp_vld%0d", k), 128'(rvld[k]), 128'(exp_rvld));
    end
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) err_exp[k] = xfer && mis[k];
    for (int i = 3; i > 0; i--) begin hv[i] = hv[i-1]; hi[i] = hi[i-1]; end
    hv[0] = xfer;
    hi[0] = g;
    if (any && !sub_rdy) begin
      locked = 1; lock_idx = g;
    end else if (xfer) begin
      lk = 0;
`ifdef TCB_ARB_RR_LOCK_EN
      lk = mgr_lck[g];
`endif
      locked   = lk;
      lock_idx = g;
      if (!lk) ptr = (g + 1) % N;
    end
    last_xfer = xfer;
    last_g    = g;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n   = 1'b0;
    mgr_vld = '0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_rsp_vld%0d", k), 128'(rvld[k]), 128'(0));
      chk($sformatf("rst_err%0d", k), 128'(err[k]), 128'(0));
      chk($sformatf("rst_sub_vld%0d", k), 128'(svld[k]), 128'(0));
      chk($sformatf("rst_rdy%0d", k), 128'(rdy[k]), 128'(0));
    end
    model_reset();
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    rst_n   = 1'b0;
    mgr_vld = '0;
    mgr_ndn = '0;
    mgr_req = '0;
    sub_rdy = 1'b0;
    sub_rsp = '0;
`ifdef TCB_ARB_RR_LOCK_EN
    mgr_lck = '0;
`endif
    for (int i = 0; i < N; i++) mgr_req[i*REQ_W +: REQ_W] = REQ_W'(72'h100 * (i + 1) + i);
    @(negedge clk);
    do_reset(3);

    // all managers valid continuously: strict rotation 0,1,2,0,1,2
    mgr_vld = '1;
    sub_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sub_rsp = RSP_W'(i + 7);
      run_cycle();
      chk("rr_seq", 128'(last_g), 128'(i % N));
    end

    // stalled grant to 2 survives manager 1 raising vld at higher priority
    mgr_vld = 3'b001;
    run_cycle();
    mgr_vld = 3'b100;
    sub_rdy = 1'b0;
    run_cycle();
    chk("stall_g0", 128'(last_g), 128'(2));
    mgr_vld = 3'b110;
    run_cycle();
    chk("stall_hold", 128'(sreq[0]), 128'(mgr_req[2*REQ_W +: REQ_W]));
    run_cycle();
    sub_rdy = 1'b1;
    run_cycle();
    chk("stall_done", 128'({last_xfer, 8'(last_g)}), 128'({1'b1, 8'd2}));
    mgr_vld = 3'b010;
    run_cycle();
    chk("stall_next", 128'(last_g), 128'(1));

    // endianness: LITTLE with request 1 mismatches, BI_NDN follows request
    mgr_vld = 3'b001;
    mgr_ndn = 3'b001;
    run_cycle();
    chk("ndn_little", 128'(sndn[0]), 128'(0));
    chk("ndn_bi", 128'(sndn[1]), 128'(1));
    chk("err_pulse", 128'(err[0]), 128'(1));
    mgr_vld = '0;
    run_cycle();
    chk("err_pulse_end", 128'(err[0]), 128'(0));
    mgr_vld = 3'b001;
    mgr_ndn = 3'b000;
    run_cycle();
    chk("ndn_bi0", 128'(sndn[1]), 128'(0));

    // reset with transfers in flight in the DLY=3 owner pipeline
    do_reset(2);
    mgr_vld = 3'b010;
    run_cycle();
    mgr_vld = 3'b001;
    run_cycle();
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      chk("rst_flush", 128'(rvld[1]), 128'(0));
    end
    mgr_vld = '1;
    run_cycle();
    chk("ptr_after_rst", 128'(last_g), 128'(0));

`ifdef TCB_ARB_RR_LOCK_EN
    // atomic lock keeps manager 0 granted across its locked transfer
    do_reset(1);
    mgr_vld = 3'b011;
    mgr_lck = 3'b001;
    run_cycle();
    chk("lck_first", 128'(last_g), 128'(0));
    mgr_lck = 3'b000;
    run_cycle();
    chk("lck_hold", 128'(last_g), 128'(0));
    run_cycle();
    chk("lck_release", 128'(last_g), 128'(1));
`endif

    // randomized traffic; managers hold vld/payload until accepted
    mgr_vld   = '0;
    last_xfer = 0;
    for (int it = 0; it < 600; it++) begin
      if (last_xfer) mgr_vld[last_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!mgr_vld[i] && $urandom_range(2) == 0) begin
          mgr_vld[i] = 1'b1;
          mgr_req[i*REQ_W +: REQ_W] = REQ_W'({$urandom(), $urandom(), $urandom()});
          r = $urandom_range(4);
          mgr_ndn[i] = (r == 4) ? 1'bx : r[0];
        end
      end
`ifdef TCB_ARB_RR_LOCK_EN
      mgr_lck = N'($urandom_range(7));
`endif
      sub_rdy = ($urandom_range(3) != 0);
      sub_rsp = RSP_W'({$urandom(), $urandom()});
      if (it == 300) do_reset(2);
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
